psum_acc_requant: RTL

- Downstream of the 3x3 PE array.
- Consumes one flat 3x3 output tile of 16-bit partial sums per input channel and accumulates tiles across cfg_num_ch channels.
- Applies bias, a rounding arithmetic right shift and ReLU, then saturates each result to OUT_W bits.
- Streams the 9 results in raster order (idx 0..8) over a valid/ready interface toward the output buffer.

---
 rtl/psum_pkg.sv | 33 +++
 rtl/psum_requant.sv | 48 ++++
 rtl/psum_acc_requant.sv | 117 +++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared widths, state enum and saturating accumulate for psum_acc_requant
package psum_pkg;

  localparam int PSUM_W = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int N_OUT  = 9;
  localparam int CH_W   = 8;

  localparam logic [3:0] TILE_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Add a sign-extended partial sum to an accumulator, clamping instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [PSUM_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-PSUM_W+1){b[PSUM_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      // Overflow: the extra top bit holds the true sign.
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - bias, rounding shift, optional ReLU (PSUM_RELU_EN) and output saturation
module psum_requant
  import psum_pkg::*;
(
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PSUM_W-1:0] bias_in,
  input  logic [3:0]        shift_in,
  output logic [OUT_W-1:0]  out_data
);

  // One extra bit of headroom so bias and rounding never wrap.
  localparam logic signed [ACC_W:0] U_MAX = (ACC_W+1)'((1 << OUT_W) - 1);
  localparam logic signed [ACC_W:0] S_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] S_MIN = (ACC_W+1)'(-(1 << (OUT_W-1)));

  logic signed [ACC_W:0] y_sum;
  logic signed [ACC_W:0] y_rnd;
  logic signed [ACC_W:0] y_shf;

  // Bias, round-half-up, arithmetic shift, then clamp to the output range.
  always_comb begin
    y_sum = {acc_in[ACC_W-1], acc_in} + {{(ACC_W-PSUM_W+1){bias_in[PSUM_W-1]}}, bias_in};
    if (shift_in != 4'd0) begin
      y_rnd = y_sum + ((ACC_W+1)'(1) << (shift_in - 4'd1));
    end else begin
      y_rnd = y_sum;
    end
    y_shf = y_rnd >>> shift_in;
`ifdef PSUM_RELU_EN
    if (y_shf[ACC_W]) begin
      out_data = '0;
    end else if (y_shf > U_MAX) begin
      out_data = '1;
    end else begin
      out_data = y_shf[OUT_W-1:0];
    end
`else
    if (y_shf > S_MAX) begin
      out_data = S_MAX[OUT_W-1:0];
    end else if (y_shf < S_MIN) begin
      out_data = S_MIN[OUT_W-1:0];
    end else begin
      out_data = y_shf[OUT_W-1:0];
    end
`endif
  end

endmodule

// File: rtl/psum_acc_requant.sv
// rtl/psum_acc_requant.sv - accumulate 3x3 psum tiles over channels, requantise (PSUM_RELU_EN selects ReLU) and stream out
module psum_acc_requant
  import psum_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_W-1:0]         cfg_num_ch,
  input  logic [3:0]              cfg_shift,
  input  logic [PSUM_W-1:0]       bias_in,
  input  logic                    psum_valid,
  output logic                    psum_ready,
  input  logic [N_OUT*PSUM_W-1:0] psum_in_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [3:0]              out_idx,
  output logic                    out_last,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic [CH_W-1:0]         num_ch_q, num_ch_d;
  logic [3:0]              shift_q, shift_d;
  logic [PSUM_W-1:0]       bias_q, bias_d;
  logic [3:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [ACC_W-1:0] acc_d [N_OUT];

  logic            accept;
  logic [CH_W-1:0] num_ch_eff;

  assign psum_ready = !rst && (state_q != DRAIN);
  assign accept     = psum_valid && psum_ready;
  assign num_ch_eff = (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
  assign out_valid  = (state_q == DRAIN);
  assign out_idx    = idx_q;
  assign out_last   = out_valid && (idx_q == TILE_LAST);
  assign busy       = (state_q != IDLE);

  // Next-state: load on the first channel, saturating add on the rest, then drain 9 results.
  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    num_ch_d = num_ch_q;
    shift_d  = shift_q;
    bias_d   = bias_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int k = 0; k < N_OUT; k++) begin
            acc_d[k] = {{(ACC_W-PSUM_W){psum_in_flat[k*PSUM_W+PSUM_W-1]}},
                        psum_in_flat[k*PSUM_W +: PSUM_W]};
          end
          ch_cnt_d = CH_W'(1);
          num_ch_d = num_ch_eff;
          shift_d  = cfg_shift;
          bias_d   = bias_in;
          state_d  = (num_ch_eff <= CH_W'(1)) ? DRAIN : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          for (int k = 0; k < N_OUT; k++) begin
            acc_d[k] = sat_add(acc_q[k], psum_in_flat[k*PSUM_W +: PSUM_W]);
          end
          ch_cnt_d = ch_cnt_q + CH_W'(1);
          if (ch_cnt_q + CH_W'(1) == num_ch_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == TILE_LAST) begin
            idx_d   = 4'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partial tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_cnt_q <= '0;
      num_ch_q <= '0;
      shift_q  <= '0;
      bias_q   <= '0;
      idx_q    <= '0;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      num_ch_q <= num_ch_d;
      shift_q  <= shift_d;
      bias_q   <= bias_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

  psum_requant u_requant (
    .acc_in   (acc_q[idx_q]),
    .bias_in  (bias_q),
    .shift_in (shift_q),
    .out_data (out_data)
  );

endmodule
